// File: rtl/instr_fetch_unit_pkg.sv
// Shared opcode map, fetch state encoding and instruction field positions.
// Pure declarations: no timing, no flow control.
package instr_fetch_unit_pkg;

    localparam logic [5:0] OP_BEQ  = 6'd14;
    localparam logic [5:0] OP_BNE  = 6'd15;
    localparam logic [5:0] OP_BGT  = 6'd16;
    localparam logic [5:0] OP_BGTE = 6'd17;
    localparam logic [5:0] OP_BLE  = 6'd18;
    localparam logic [5:0] OP_BLEQ = 6'd19;
    localparam logic [5:0] OP_J    = 6'd20;
    localparam logic [5:0] OP_JR   = 6'd21;
    localparam logic [5:0] OP_JAL  = 6'd22;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_BR,
        S_HALT
    } fetch_state_t;

    function automatic logic [5:0] get_op(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    // jr and conditional branches park in WAIT_BR until the executor resolves them
    function automatic logic needs_resolve(input logic [5:0] op);
        return (op == OP_JR) || ((op >= OP_BEQ) && (op <= OP_BLEQ));
    endfunction

endpackage

// File: rtl/instr_fetch_unit_mem.sv
// 2**AW x 32 instruction RAM, one write and one read port, no reset.
// Read data appears one clock after the address; writes are never stalled.
module instr_fetch_unit_mem #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [(1<<AW)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction sequencer: PC, program RAM and one-at-a-time issue over valid/ready.
// First issue two cycles after run; instruction held stable until instr_ready, branches stall for resolution.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int         AW      = 9,
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic          run,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          br_resolve_valid,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic          link_valid,
    output logic [AW-1:0] link_addr,
    output logic [AW-1:0] pc,
    output logic          halted
);

    fetch_state_t  state, state_nxt;
    logic [31:0]   mem_rdata;
    logic [31:0]   instr_q;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] br_off;
    logic [AW-1:0] br_dest;
    logic [5:0]    cur_op;
    logic          link_set;
    logic          mem_we;

    // program loads only while the sequencer is parked
    assign mem_we = prog_we && ((state == S_IDLE) || (state == S_HALT));

    instr_fetch_unit_mem #(.AW(AW)) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc),
        .rd_data (mem_rdata)
    );

    // RAM output is live during ISSUE; instr_q keeps the word for WAIT_BR
    assign instruction = (state == S_ISSUE) ? mem_rdata : instr_q;
    assign cur_op      = get_op(instruction);
    assign pc_inc      = pc + AW'(1);
    assign br_off      = AW'($signed(instr_q[IMM_MSB:IMM_LSB]));
    assign br_dest     = pc_inc + br_off;
    assign halted      = (state == S_HALT);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_valid = 1'b0;
        link_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (cur_op == HALT_OP) begin
                    state_nxt = S_HALT;
                end else begin
                    instr_valid = 1'b1;
                    if (instr_ready) begin
                        state_nxt = S_FETCH;
                        if (cur_op == OP_J) begin
                            pc_nxt = instruction[AW-1:0];
                        end else if (cur_op == OP_JAL) begin
                            pc_nxt   = instruction[AW-1:0];
                            link_set = 1'b1;
                        end else if (needs_resolve(cur_op)) begin
                            state_nxt = S_WAIT_BR;
                        end else begin
                            pc_nxt = pc_inc;
                        end
                    end
                end
            end
            S_WAIT_BR: begin
                if (br_resolve_valid) begin
                    state_nxt = S_FETCH;
                    if (get_op(instr_q) == OP_JR) begin
                        pc_nxt = br_target;
                    end else if (br_taken) begin
                        pc_nxt = br_dest;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            S_HALT: begin
                if (!run) begin
                    state_nxt = S_IDLE;
                    pc_nxt    = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            instr_q    <= '0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            link_valid <= link_set;
            if (state == S_ISSUE) begin
                instr_q <= mem_rdata;
            end
            if (link_set) begin
                link_addr <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table-driven program trace plus hand-written
// sequences for stall, wrap, dropped writes and reset during branch wait.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [8:0]  prog_addr;
    logic [31:0] prog_data;
    logic        run;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_resolve_valid;
    logic        br_taken;
    logic [8:0]  br_target;
    logic        link_valid;
    logic [8:0]  link_addr;
    logic [8:0]  pc;
    logic        halted;

    int tests = 0;
    int fails = 0;

    instr_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .prog_we          (prog_we),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .run              (run),
        .instruction      (instruction),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .br_resolve_valid (br_resolve_valid),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .link_valid       (link_valid),
        .link_addr        (link_addr),
        .pc               (pc),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  pc;
        logic [31:0] ins;
        logic        resolve;
        logic        taken;
        logic [8:0]  tgt;
        logic        link;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'd0, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic prog(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!instr_valid) begin
            fails++;
            $display("FAIL %s: instr_valid got 0 expected 1 within 30 cycles", name);
        end
    endtask

    task automatic handshake();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic resolve(input logic taken, input logic [8:0] tgt);
        @(negedge clk);
        br_resolve_valid = 1'b1;
        br_taken         = taken;
        br_target        = tgt;
        @(negedge clk);
        br_resolve_valid = 1'b0;
        br_taken         = 1'b0;
    endtask

    logic [31:0] i_add, i_sub, i_j4, i_beq, i_add5, i_add6, i_jal, i_jr, i_add8, i_halt;
    logic [31:0] i_b0, i_bneg, i_a1ff;
    int vcnt;

    initial begin
        reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; run = 1'b0;
        instr_ready = 1'b0; br_resolve_valid = 1'b0; br_taken = 1'b0; br_target = '0;

        i_add  = mk(6'd1, 16'h0011);  i_sub  = mk(6'd2, 16'h0022);
        i_j4   = mk(6'd20, 16'h0004); i_beq  = mk(6'd14, 16'hFFFD);
        i_add5 = mk(6'd1, 16'h0055);  i_add6 = mk(6'd1, 16'h0066);
        i_jal  = mk(6'd22, 16'h0040); i_jr   = mk(6'd21, 16'h0000);
        i_add8 = mk(6'd3, 16'h0088);  i_halt = mk(6'h3F, 16'h0000);
        i_b0   = mk(6'd1, 16'h00B0);  i_a1ff = mk(6'd1, 16'h01FF);
        i_bneg = mk(6'd14, 16'hFFFD);

        vecs[0]  = '{9'd0,   i_add,  1'b0, 1'b0, 9'd0, 1'b0};
        vecs[1]  = '{9'd1,   i_sub,  1'b0, 1'b0, 9'd0, 1'b0};
        vecs[2]  = '{9'd2,   i_j4,   1'b0, 1'b0, 9'd0, 1'b0};
        vecs[3]  = '{9'd4,   i_beq,  1'b1, 1'b1, 9'd0, 1'b0};
        vecs[4]  = '{9'd2,   i_j4,   1'b0, 1'b0, 9'd0, 1'b0};
        vecs[5]  = '{9'd4,   i_beq,  1'b1, 1'b0, 9'd0, 1'b0};
        vecs[6]  = '{9'd5,   i_add5, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[7]  = '{9'd6,   i_add6, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[8]  = '{9'd7,   i_jal,  1'b0, 1'b0, 9'd0, 1'b1};
        vecs[9]  = '{9'h040, i_jr,   1'b1, 1'b0, 9'd8, 1'b0};
        vecs[10] = '{9'd8,   i_add8, 1'b0, 1'b0, 9'd0, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_link_valid", link_valid, 0);
        chk("rst_link_addr", link_addr, 0);
        chk("rst_halted", halted, 0);
        reset = 1'b1;

        prog(9'd0, i_add);  prog(9'd1, i_sub);  prog(9'd2, i_j4);   prog(9'd3, i_halt);
        prog(9'd4, i_beq);  prog(9'd5, i_add5); prog(9'd6, i_add6); prog(9'd7, i_jal);
        prog(9'h040, i_jr); prog(9'd8, i_add8); prog(9'd9, i_halt);

        run = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wait_valid($sformatf("vec%0d_valid", i));
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
            chk($sformatf("vec%0d_instr", i), instruction, vecs[i].ins);
            handshake();
            chk($sformatf("vec%0d_link_valid", i), link_valid, vecs[i].link);
            if (vecs[i].link) begin
                chk($sformatf("vec%0d_link_addr", i), link_addr, vecs[i].pc + 9'd1);
                chk($sformatf("vec%0d_link_pc", i), pc, 9'h040);
                @(negedge clk);
                chk($sformatf("vec%0d_link_pulse_end", i), link_valid, 0);
            end
            if (vecs[i].resolve) begin
                resolve(vecs[i].taken, vecs[i].tgt);
            end
        end

        // HALT reached at pc 9, never issued
        vcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (instr_valid) vcnt++;
        end
        chk("halt_no_valid", vcnt, 0);
        chk("halt_flag", halted, 1);
        chk("halt_pc", pc, 9);

        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_halted_clr", halted, 0);
        chk("idle_pc_clr", pc, 0);

        // program B: stall at pc 0, negative branch to 511, wrap to 0
        prog(9'd0, i_b0); prog(9'd1, i_bneg); prog(9'h1FF, i_a1ff);
        run = 1'b1;
        @(negedge clk);
        wait_valid("b_first_valid");
        chk("b_first_pc", pc, 0);
        chk("b_first_instr", instruction, i_b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                run = 1'b0; prog_we = 1'b1; prog_addr = 9'h1FF; prog_data = 32'hDEADBEEF;
            end else if (k == 2) begin
                prog_we = 1'b0; br_resolve_valid = 1'b1; br_taken = 1'b1; br_target = 9'h055;
            end else if (k == 3) begin
                br_resolve_valid = 1'b0; br_taken = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("stall%0d_instr", k), instruction, i_b0);
            chk($sformatf("stall%0d_valid", k), instr_valid, 1);
            chk($sformatf("stall%0d_pc", k), pc, 0);
        end
        handshake();
        wait_valid("b_beq_valid");
        chk("b_beq_pc", pc, 1);
        chk("b_beq_instr", instruction, i_bneg);
        handshake();
        resolve(1'b1, 9'd0);
        wait_valid("b_511_valid");
        chk("b_511_pc", pc, 9'h1FF);
        chk("b_511_instr_unwritten", instruction, i_a1ff);
        handshake();
        wait_valid("b_wrap_valid");
        chk("b_wrap_pc", pc, 0);
        chk("b_wrap_instr", instruction, i_b0);
        handshake();
        wait_valid("b_beq2_valid");
        chk("b_beq2_pc", pc, 1);
        handshake();

        // now waiting for branch resolution; reset between clock edges
        #2 reset = 1'b0;
        #1;
        chk("async_valid", instr_valid, 0);
        chk("async_pc", pc, 0);
        chk("async_instr", instruction, 0);
        chk("async_link_addr", link_addr, 0);
        chk("async_link_valid", link_valid, 0);
        chk("async_halted", halted, 0);
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b1;
        wait_valid("restart_valid");
        chk("restart_pc", pc, 0);
        chk("restart_instr", instruction, i_b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
